// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: byte-addressed, little-endian 32-bit data memory for the
// RV32 load/store unit, behind a ready/valid request port with a programmable
// number of wait states between accept and response.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   req_valid/ready request handshake; one request in flight at a time
//   req_we          1 = store, 0 = load
//   req_size        00 byte, 01 half, 10 word, 11 reserved (faults)
//   req_unsigned    zero-extend byte/half loads
//   req_addr        byte address
//   req_wdata       right-aligned store data
//   rsp_valid       single-cycle response pulse
//   rsp_rdata       extended load data; 0 for stores and faults
//   rsp_err         access faulted (range, reserved size, optional misalign)
//
// Build option: define DMEM_MISALIGN_TRAP_EN to fault misaligned half/word
// accesses; otherwise the low address bits are forced to alignment.
module data_memory_ctrl #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
    localparam int unsigned HI_LSB = IDX_W + 2;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                ready_q, ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;

    logic [31:0]         mem_q [DEPTH_WORDS];

    // Effective request: live inputs at the accept edge, latched copy after.
    logic                eff_we_c;
    logic [1:0]          eff_size_c;
    logic                eff_uns_c;
    logic [ADDR_W-1:0]   eff_addr_c;
    logic [31:0]         eff_wdata_c;

    logic                accept_c;
    logic                commit_c;
    logic                range_err_c;
    logic                size_err_c;
    logic                fault_c;
    logic [1:0]          lane_c;
    logic [IDX_W-1:0]    idx_c;
    logic [31:0]         rd_word_c;
    logic [31:0]         rd_shift_c;
    logic [31:0]         load_data_c;
    logic [3:0]          wr_be_c;
    logic [31:0]         wr_data_c;
    logic                mem_we_c;
`ifdef DMEM_MISALIGN_TRAP_EN
    logic                misalign_c;
`endif

    // Request source selection
    always_comb begin
        if (state_q == S_IDLE) begin
            eff_we_c    = req_we;
            eff_size_c  = req_size;
            eff_uns_c   = req_unsigned;
            eff_addr_c  = req_addr;
            eff_wdata_c = req_wdata;
        end else begin
            eff_we_c    = we_q;
            eff_size_c  = size_q;
            eff_uns_c   = uns_q;
            eff_addr_c  = addr_q;
            eff_wdata_c = wdata_q;
        end
    end

    // Address decode, fault detection and lane alignment
    always_comb begin
        range_err_c = (eff_addr_c >> HI_LSB) != '0;
        size_err_c  = (eff_size_c == 2'b11);
        idx_c       = eff_addr_c[HI_LSB-1:2];
        // Lane is always aligned; under the trap build misalignment faults
        // anyway, so the forced lane never reaches memory there.
        case (eff_size_c)
            2'b01:   lane_c = {eff_addr_c[1], 1'b0};
            2'b10:   lane_c = 2'b00;
            default: lane_c = eff_addr_c[1:0];
        endcase
`ifdef DMEM_MISALIGN_TRAP_EN
        misalign_c = ((eff_size_c == 2'b01) && eff_addr_c[0]) ||
                     ((eff_size_c == 2'b10) && (eff_addr_c[1:0] != 2'b00));
        fault_c    = range_err_c || size_err_c || misalign_c;
`else
        fault_c    = range_err_c || size_err_c;
`endif
    end

    // Load path: shift selected lanes to bit 0, then extend
    always_comb begin
        rd_word_c  = mem_q[idx_c];
        rd_shift_c = rd_word_c >> {lane_c, 3'b000};
        case (eff_size_c)
            2'b00:   load_data_c = eff_uns_c ? {24'd0, rd_shift_c[7:0]}
                                             : {{24{rd_shift_c[7]}}, rd_shift_c[7:0]};
            2'b01:   load_data_c = eff_uns_c ? {16'd0, rd_shift_c[15:0]}
                                             : {{16{rd_shift_c[15]}}, rd_shift_c[15:0]};
            default: load_data_c = rd_shift_c;
        endcase
    end

    // Store path: lane enables and positioned data
    always_comb begin
        wr_data_c = eff_wdata_c << {lane_c, 3'b000};
        case (eff_size_c)
            2'b00:   wr_be_c = 4'b0001 << lane_c;
            2'b01:   wr_be_c = 4'b0011 << lane_c;
            2'b10:   wr_be_c = 4'b1111;
            default: wr_be_c = 4'b0000;
        endcase
    end

    // Next-state, request latch, commit and registered-output computation
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        size_d   = size_q;
        uns_d    = uns_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        commit_c = 1'b0;
        accept_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid && ready_q) begin
                    accept_c = 1'b1;
                    we_d     = req_we;
                    size_d   = req_size;
                    uns_d    = req_unsigned;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    end else begin
                        // Zero wait states: the accept edge is the commit edge.
                        state_d  = S_RESP;
                        commit_c = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d  = S_RESP;
                    commit_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d     = (state_d == S_IDLE);
        rsp_valid_d = commit_c;
        rdata_d     = (commit_c && !eff_we_c && !fault_c) ? load_data_c : 32'd0;
        err_d       = commit_c && fault_c;
        // Reset wins over a store committing on the same edge.
        mem_we_c    = commit_c && eff_we_c && !fault_c && !rst;
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    // Storage array; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be_c[b]) begin
                    mem_q[idx_c][8*b +: 8] <= wr_data_c[8*b +: 8];
                end
            end
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: two instances (0 and 3 wait states) sharing the
// request payload bus, each checked against a byte-array reference model.
module tb_data_memory_ctrl;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned NBYTE = DEPTH * 4;

    logic        clk;
    logic        rst;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        valid0, valid3;
    logic        ready0, ready3;
    logic        rv0, rv3;
    logic [31:0] rd0, rd3;
    logic        err0, err3;

    int checks = 0;
    int errors = 0;

    logic [7:0] mm [2][NBYTE];

    data_memory_ctrl #(.DEPTH_WORDS(DEPTH), .ADDR_W(32), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(valid0), .req_ready(ready0),
        .req_we(we), .req_size(size), .req_unsigned(uns), .req_addr(addr),
        .req_wdata(wdata), .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(err0)
    );

    data_memory_ctrl #(.DEPTH_WORDS(DEPTH), .ADDR_W(32), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(valid3), .req_ready(ready3),
        .req_we(we), .req_size(size), .req_unsigned(uns), .req_addr(addr),
        .req_wdata(wdata), .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic g_ready(input int d);
        return (d != 0) ? ready3 : ready0;
    endfunction
    function automatic logic g_rv(input int d);
        return (d != 0) ? rv3 : rv0;
    endfunction
    function automatic logic [31:0] g_rd(input int d);
        return (d != 0) ? rd3 : rd0;
    endfunction
    function automatic logic g_err(input int d);
        return (d != 0) ? err3 : err0;
    endfunction

    task automatic set_valid(input int d, input logic v);
        if (d != 0) valid3 = v;
        else        valid0 = v;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain byte array, alignment by arithmetic, extension by width.
    task automatic model(input int d, input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er);
        logic [31:0] aa;
        logic [31:0] v;
        int nb;
        rd = 32'd0;
        er = 1'b0;
        if (a >= 32'(NBYTE) || sz == 2'b11) er = 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)) er = 1'b1;
`endif
        if (!er) begin
            nb = 1 << sz;
            aa = a - (a % 32'(nb));
            if (w) begin
                for (int i = 0; i < nb; i++) mm[d][aa + 32'(i)] = wd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < nb; i++) v = v | (32'(mm[d][aa + 32'(i)]) << (8*i));
                if (!u && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
                rd = v;
            end
        end
    endtask

    // One full transaction; entered and left #1 after a rising edge.
    task automatic xact(input int d, input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd, input logic hold,
                        output logic [31:0] got_rd, output logic got_err);
        int          lat;
        int          n;
        logic        rdy;
        logic [31:0] erd;
        logic        eer;
        lat    = (d != 0) ? 4 : 1;
        got_rd = 32'd0;
        got_err = 1'b0;
        we = w; size = sz; uns = u; addr = a; wdata = wd;
        set_valid(d, 1'b1);
        n = 0;
        do begin
            rdy = g_ready(d);
            @(posedge clk); #1;
            n++;
        end while (!rdy && n < 20);
        chk("accept", 32'(rdy), 32'd1);
        if (!hold) set_valid(d, 1'b0);
        model(d, w, sz, u, a, wd, erd, eer);
        for (int k = 1; k <= lat; k++) begin
            chk("rsp_valid_timing", 32'(g_rv(d)), 32'(k == lat));
            chk("ready_busy", 32'(g_ready(d)), 32'd0);
            if (k == lat) begin
                got_rd  = g_rd(d);
                got_err = g_err(d);
                chk("rsp_rdata", got_rd, erd);
                chk("rsp_err", 32'(got_err), 32'(eer));
            end else begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        chk("rsp_pulse_end", 32'(g_rv(d)), 32'd0);
        chk("ready_back", 32'(g_ready(d)), 32'd1);
        set_valid(d, 1'b0);
    endtask

    logic [31:0] r;
    logic        e;
    logic [31:0] old40;
    logic [31:0] ra;

    initial begin
        rst = 1'b1; valid0 = 1'b0; valid3 = 1'b0;
        we = 1'b0; size = 2'b00; uns = 1'b0; addr = 32'd0; wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("rst_ready0", 32'(ready0), 32'd1);
        chk("rst_rv0", 32'(rv0), 32'd0);
        chk("rst_rd0", rd0, 32'd0);
        chk("rst_err0", 32'(err0), 32'd0);
        chk("rst_ready3", 32'(ready3), 32'd1);
        chk("rst_rv3", 32'(rv3), 32'd0);
        chk("rst_rd3", rd3, 32'd0);
        chk("rst_err3", 32'(err3), 32'd0);

        // Fill both arrays so every later load has defined data
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < int'(DEPTH); i++)
                xact(d, 1'b1, 2'b10, 1'b0, 32'(i*4), $urandom, 1'b0, r, e);

        // Word store / load round trip
        xact(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, r, e);
        xact(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 1'b0, r, e);
        chk("lw_10", r, 32'hDEAD_BEEF);
        chk("lw_10_err", 32'(e), 32'd0);

        // Byte store into existing word, signed/unsigned byte loads
        xact(0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344, 1'b0, r, e);
        xact(0, 1'b1, 2'b00, 1'b0, 32'h21, 32'h0000_00AA, 1'b0, r, e);
        xact(0, 1'b0, 2'b00, 1'b0, 32'h21, 32'd0, 1'b0, r, e);
        chk("lb_21", r, 32'hFFFF_FFAA);
        xact(0, 1'b0, 2'b00, 1'b1, 32'h21, 32'd0, 1'b0, r, e);
        chk("lbu_21", r, 32'h0000_00AA);
        xact(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 1'b0, r, e);
        chk("lw_20", r, 32'h1122_AA44);

        // Upper halfword store, signed/unsigned half loads
        xact(0, 1'b1, 2'b10, 1'b0, 32'h30, 32'd0, 1'b0, r, e);
        xact(0, 1'b1, 2'b01, 1'b0, 32'h32, 32'h0000_8001, 1'b0, r, e);
        xact(0, 1'b0, 2'b01, 1'b0, 32'h32, 32'd0, 1'b0, r, e);
        chk("lh_32", r, 32'hFFFF_8001);
        xact(0, 1'b0, 2'b01, 1'b1, 32'h32, 32'd0, 1'b0, r, e);
        chk("lhu_32", r, 32'h0000_8001);
        xact(0, 1'b0, 2'b10, 1'b0, 32'h30, 32'd0, 1'b0, r, e);
        chk("lw_30", r, 32'h8001_0000);

        // Faults: first out-of-range word, reserved size, misaligned word
        xact(0, 1'b0, 2'b10, 1'b0, 32'(NBYTE), 32'd0, 1'b0, r, e);
        chk("range_err", 32'(e), 32'd1);
        chk("range_rd", r, 32'd0);
        xact(0, 1'b0, 2'b11, 1'b0, 32'h10, 32'd0, 1'b0, r, e);
        chk("size11_err", 32'(e), 32'd1);
        xact(0, 1'b0, 2'b10, 1'b0, 32'h13, 32'd0, 1'b0, r, e);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("misalign_err", 32'(e), 32'd1);
        chk("misalign_rd", r, 32'd0);
`else
        chk("misalign_err", 32'(e), 32'd0);
        chk("misalign_rd", r, 32'hDEAD_BEEF);
`endif

        // Wait states with req_valid held through the whole transaction
        xact(1, 1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFE_F00D, 1'b0, r, e);
        xact(1, 1'b0, 2'b10, 1'b0, 32'h40, 32'd0, 1'b1, r, e);
        chk("lw3_40", r, 32'hCAFE_F00D);
        old40 = r;

        // Reset while a store waits: the store must vanish
        we = 1'b1; size = 2'b10; uns = 1'b0; addr = 32'h40; wdata = 32'h0000_0055;
        valid3 = 1'b1;
        @(posedge clk); #1;
        valid3 = 1'b0;
        chk("rstmid_in_wait", 32'(ready3), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstmid_ready", 32'(ready3), 32'd1);
        for (int k = 0; k < 5; k++) begin
            chk("rstmid_no_rsp", 32'(rv3), 32'd0);
            @(posedge clk); #1;
        end
        xact(1, 1'b0, 2'b10, 1'b0, 32'h40, 32'd0, 1'b0, r, e);
        chk("rstmid_old", r, old40);
        chk("rstmid_not55", 32'(r !== 32'h55), 32'd1);

        // Randomized traffic against the model
        for (int it = 0; it < 400; it++) begin
            case ($urandom_range(0, 9))
                0:       ra = 32'(NBYTE) + $urandom_range(0, 1000);
                1:       ra = $urandom | 32'h8000_0000;
                default: ra = $urandom_range(0, NBYTE - 1);
            endcase
            xact(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 ra, $urandom, 1'($urandom_range(0, 1)), r, e);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
